// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state encoding and channel constants for the decoder scan sequencer
package dec_pkg;

    localparam int NUM_CH = 8;
    localparam int CH_W   = $clog2(NUM_CH);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SEEK  = 2'd1,
        ST_DWELL = 2'd2,
        ST_GAP   = 2'd3
    } dec_state_t;

endpackage

// File: rtl/dec_pri_wrap.sv
// rtl/dec_pri_wrap.sv - lowest enabled channel at or above ptr, wrapping to the lowest enabled channel
module dec_pri_wrap
    import dec_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [CH_W-1:0]   ptr,
    output logic [CH_W-1:0]   idx,
    output logic              any
);

    always_comb begin
        idx = '0;
        any = |mask;
        // Descending scans leave the lowest hit; the second pass overrides with the lowest hit at or above ptr.
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = CH_W'(i);
            end
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (mask[i] && (i >= int'(ptr))) begin
                idx = CH_W'(i);
            end
        end
    end

endmodule

// File: rtl/dec_scan_seq.sv
// rtl/dec_scan_seq.sv - sweeps enabled channels of a 3x8 decoder with dwell time and break-before-make gaps
module dec_scan_seq
    import dec_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic               stop,
    input  logic               cont,
    input  logic [NUM_CH-1:0]  ch_mask,
    input  logic [DWELL_W-1:0] dwell,
    output logic [CH_W-1:0]    sel,
    output logic               en,
    output logic               busy,
    output logic               done
);

    dec_state_t         r_state;
    dec_state_t         w_next_state;
    logic [CH_W-1:0]    r_ptr;
    logic [CH_W-1:0]    w_next_ptr;
    logic [CH_W-1:0]    r_sel;
    logic [CH_W-1:0]    w_next_sel;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_next_cnt;
    logic               r_en;
    logic [CH_W-1:0]    w_idx;
    logic               w_any;
    logic               w_eos;

    dec_pri_wrap u_pri (
        .mask (ch_mask),
        .ptr  (r_ptr),
        .idx  (w_idx),
        .any  (w_any)
    );

    // The sweep ends when no channel above the current one is enabled in the live mask.
    assign w_eos = ((ch_mask >> r_sel) >> 1) == '0;

    always_comb begin
        w_next_state = r_state;
        w_next_ptr   = r_ptr;
        w_next_sel   = r_sel;
        w_next_cnt   = r_cnt;
        done         = 1'b0;
        if (stop) begin
            w_next_state = ST_IDLE;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start && (ch_mask != '0)) begin
                        w_next_state = ST_SEEK;
                        w_next_ptr   = '0;
                    end
                end
                ST_SEEK: begin
                    if (w_any) begin
                        w_next_sel   = w_idx;
                        w_next_cnt   = (dwell == '0) ? DWELL_W'(1) : dwell;
                        w_next_state = ST_DWELL;
                    end else begin
                        w_next_state = ST_IDLE;
                    end
                end
                ST_DWELL: begin
                    w_next_cnt = r_cnt - DWELL_W'(1);
                    if (r_cnt <= DWELL_W'(1)) begin
                        w_next_state = ST_GAP;
                    end
                end
                ST_GAP: begin
                    done = w_eos;
                    if (w_eos) begin
                        w_next_ptr   = '0;
                        w_next_state = cont ? ST_SEEK : ST_IDLE;
                    end else begin
                        w_next_ptr   = r_sel + CH_W'(1);
                        w_next_state = ST_SEEK;
                    end
                end
                default: w_next_state = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
            r_sel   <= '0;
            r_cnt   <= '0;
            r_en    <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_ptr   <= w_next_ptr;
            r_sel   <= w_next_sel;
            r_cnt   <= w_next_cnt;
            r_en    <= (w_next_state == ST_DWELL);
        end
    end

    assign sel  = r_sel;
    assign en   = r_en;
    assign busy = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dec_scan_seq.sv
// tb/tb_dec_scan_seq.sv - randomized and directed self-checking bench for dec_scan_seq
module tb_dec_scan_seq;

    localparam int DW = 8;

    logic          clk     = 1'b0;
    logic          rst_n   = 1'b0;
    logic          start   = 1'b0;
    logic          stop    = 1'b0;
    logic          cont    = 1'b0;
    logic [7:0]    ch_mask = 8'h00;
    logic [DW-1:0] dwell   = '0;
    logic [2:0]    sel;
    logic          en;
    logic          busy;
    logic          done;

    int n_chk  = 0;
    int n_err  = 0;
    int n_done = 0;
    int tr[$];

    dec_scan_seq #(.DWELL_W(DW)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .stop    (stop),
        .cont    (cont),
        .ch_mask (ch_mask),
        .dwell   (dwell),
        .sel     (sel),
        .en      (en),
        .busy    (busy),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Model: a scan is a series of slots; slot position k=0 is the search cycle,
    // 1..len are the enabled cycles and len+1 is the gap cycle.
    typedef struct packed {
        bit active;
        int k;
        int len;
        int sel;
        int ptr;
    } mdl_t;

    mdl_t m;

    function automatic int next_ch(logic [7:0] mk, int p);
        for (int off = 0; off < 8; off++) begin
            if (mk[(p + off) % 8]) return (p + off) % 8;
        end
        return 0;
    endfunction

    function automatic bit end_of_sweep(logic [7:0] mk, int s);
        for (int j = s + 1; j < 8; j++) begin
            if (mk[j]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic mdl_t mstep(mdl_t c, bit st, bit sp, bit ct, logic [7:0] mk, int dw);
        mdl_t n;
        n = c;
        if (sp) begin
            n.active = 1'b0;
        end else if (!c.active) begin
            if (st && mk != 8'h00) begin
                n.active = 1'b1;
                n.k      = 0;
                n.ptr    = 0;
            end
        end else if (c.k == 0) begin
            if (mk == 8'h00) begin
                n.active = 1'b0;
            end else begin
                n.sel = next_ch(mk, c.ptr);
                n.len = (dw == 0) ? 1 : dw;
                n.k   = 1;
            end
        end else if (c.k <= c.len) begin
            n.k = c.k + 1;
        end else if (end_of_sweep(mk, c.sel)) begin
            if (ct) begin
                n.k   = 0;
                n.ptr = 0;
            end else begin
                n.active = 1'b0;
            end
        end else begin
            n.k   = 0;
            n.ptr = (c.sel + 1) % 8;
        end
        return n;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m <= '0;
        else        m <= mstep(m, start, stop, cont, ch_mask, int'(dwell));
    end

    logic       exp_en;
    logic       exp_done;
    logic [7:0] exp_dec;
    logic [7:0] dec_out;

    assign exp_en   = m.active && (m.k >= 1) && (m.k <= m.len);
    assign exp_done = m.active && (m.k == m.len + 1) && end_of_sweep(ch_mask, m.sel) && !stop;
    assign exp_dec  = exp_en ? (8'h01 << m.sel) : 8'h00;
    assign dec_out  = en ? (8'h01 << sel) : 8'h00;

    task automatic chk(input string nm, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            chk("busy", int'(busy), int'(m.active));
            chk("en", int'(en), int'(exp_en));
            chk("sel", int'(sel), m.sel);
            chk("done", int'(done), int'(exp_done));
            chk("decoder", int'(dec_out), int'(exp_dec));
            if (en)   tr.push_back(int'(sel));
            if (done) n_done++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int bound);
        int c = 0;
        while (busy && c < bound) begin
            tick();
            c++;
        end
        chk("wait_idle", int'(busy), 0);
    endtask

    task automatic wait_en_sel(input int ch, input int bound);
        int c = 0;
        while (!(en && int'(sel) == ch) && c < bound) begin
            tick();
            c++;
        end
        chk("wait_ch", int'(en && int'(sel) == ch), 1);
    endtask

    task automatic chk_trace(input string nm, input int base, input int e[$]);
        chk({nm, "_len"}, tr.size() - base, e.size());
        for (int i = 0; i < e.size(); i++) begin
            if (base + i < tr.size()) chk(nm, tr[base + i], e[i]);
        end
    endtask

    initial begin
        int exp_q[$];
        int base;
        int dbase;

        // Full single sweep, start held through reset release
        ch_mask = 8'hFF; dwell = 8'd2; cont = 1'b0; start = 1'b1;
        #3;
        chk("rst_busy", int'(busy), 0);
        chk("rst_en", int'(en), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_done", int'(done), 0);
        base = tr.size(); dbase = n_done;
        #9 rst_n = 1'b1;
        tick();
        start = 1'b0;
        chk("lat_seek_busy", int'(busy), 1);
        chk("lat_seek_en", int'(en), 0);
        tick();
        chk("lat_dwell_en", int'(en), 1);
        chk("lat_dwell_sel", int'(sel), 0);
        wait_idle(100);
        exp_q.delete();
        for (int c = 0; c < 8; c++) begin
            exp_q.push_back(c);
            exp_q.push_back(c);
        end
        chk_trace("sweep_ff", base, exp_q);
        chk("sweep_ff_done", n_done - dbase, 1);

        // Continuous sweeps over 0x91 with zero dwell
        ch_mask = 8'h91; dwell = 8'd0; cont = 1'b1;
        base = tr.size(); dbase = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (27) tick();
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("cont_stop_busy", int'(busy), 0);
        exp_q = {0, 4, 7, 0, 4, 7, 0, 4, 7};
        chk_trace("cont_91", base, exp_q);
        chk("cont_91_done", n_done - dbase, 3);

        // Empty mask never starts
        ch_mask = 8'h00; cont = 1'b0; start = 1'b1;
        repeat (5) begin
            tick();
            chk("empty_busy", int'(busy), 0);
            chk("empty_en", int'(en), 0);
        end
        start = 1'b0;

        // Stop during channel 3 dwell, then restart from channel 0
        ch_mask = 8'hFF; dwell = 8'd4;
        dbase = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en_sel(3, 100);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        chk("stop_en", int'(en), 0);
        chk("stop_busy", int'(busy), 0);
        chk("stop_done", n_done - dbase, 0);
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        chk("restart_en", int'(en), 1);
        chk("restart_sel", int'(sel), 0);
        stop = 1'b1;
        tick();
        stop = 1'b0;

        // Asynchronous reset between clock edges during dwell
        dwell = 8'd5;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en_sel(2, 100);
        #2 rst_n = 1'b0;
        #1;
        chk("async_en", int'(en), 0);
        chk("async_busy", int'(busy), 0);
        chk("async_sel", int'(sel), 0);
        chk("async_done", int'(done), 0);
        #4 rst_n = 1'b1;
        tick();

        // Mask shrinks during channel 2 dwell: channel 2 completes and the sweep ends
        ch_mask = 8'hFF; dwell = 8'd3; cont = 1'b0;
        base = tr.size(); dbase = n_done;
        start = 1'b1;
        tick();
        start = 1'b0;
        wait_en_sel(2, 100);
        ch_mask = 8'h01;
        wait_idle(50);
        exp_q = {0, 0, 0, 1, 1, 1, 2, 2, 2};
        chk_trace("mask_shrink", base, exp_q);
        chk("mask_shrink_done", n_done - dbase, 1);

        // Randomized traffic against the model
        for (int cyc = 0; cyc < 2000; cyc++) begin
            start = ($urandom_range(0, 3) == 0);
            stop  = ($urandom_range(0, 59) == 0);
            if ($urandom_range(0, 24) == 0)
                ch_mask = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            if ($urandom_range(0, 24) == 0) dwell = DW'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) cont = ~cont;
            tick();
        end
        start = 1'b0;
        stop  = 1'b1;
        tick();
        stop = 1'b0;
        tick();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
